prog_byte_mem: RTL and testbench
================================

# prog_byte_mem

Loadable, parametrised program memory for the MCU51 core. It replaces the hard-wired opcode table with a RAM-backed store. The store is filled at run time from a byte-stream loader port with a valid/ready handshake, auto-incrementing address and an optional checksum check. The CPU-side fetch port keeps the established contract: active-low chip select, falling-edge registered read and tri-stated output.

## Interface
Parameters:
- ADDRWIDTH, 8, fetch/load address width; DEPTH = 2**ADDRWIDTH bytes
- DATAWIDTH, 8, word width (8 for MCU51)
- NOP_WORD, 8'h00, word returned to the CPU while a load is in progress

Ports:
- clk  in  1  single clock; fetch register on negedge, load logic on posedge
- rst  in  1  asynchronous, active-high reset
- CS  in  1  fetch chip select, active low
- addr  in  ADDRWIDTH  fetch address
- dout  out  DATAWIDTH  fetch data; high-Z when CS=1
- ld_start  in  1  one-cycle pulse, begins a load (ignored unless IDLE)
- ld_base  in  ADDRWIDTH  first load address, sampled on ld_start
- ld_len  in  ADDRWIDTH+1  byte count, sampled on ld_start (0..DEPTH)
- ld_chk  in  DATAWIDTH  expected checksum, sampled on ld_start
- ld_valid  in  1  loader byte valid
- ld_data  in  DATAWIDTH  loader byte
- ld_ready  out  1  block accepts a byte this cycle
- busy  out  1  load in progress (state not IDLE)
- done  out  1  one-cycle pulse at load completion
- chk_err  out  1  sticky checksum mismatch; cleared by next accepted ld_start

## Operation
- FSM states: IDLE, LOAD, CHECK.
- IDLE: ld_ready=0. On ld_start, latch base, len and chk. Clear the byte counter, sum and chk_err. Go to LOAD, or go straight to CHECK if ld_len=0.
- LOAD: ld_ready=1. A byte transfers when ld_valid and ld_ready are both 1 at a posedge.
  - On transfer: mem[ptr] <= ld_data; ptr <= ptr+1 modulo DEPTH (wraps from DEPTH-1 to 0); sum <= sum + ld_data modulo 2**DATAWIDTH; cnt <= cnt+1.
  - When cnt reaches len on the transfer, go to CHECK.
- CHECK: lasts one cycle. chk_err <= (sum != chk), then done=1 and return to IDLE.
- ld_start while busy is ignored.
- Fetch: on every negedge, data <= busy ? NOP_WORD : mem[addr].
  - dout = CS ? 'z : data.
  - The CPU therefore executes NOPs for the whole load.
- Memory contents are not affected by rst. A reset in mid-load leaves the bytes already written in place and drops the rest.

## Timing
- Reset values: state=IDLE, data=0 (dout=0 when CS=0), ld_ready=0, busy=0, done=0, chk_err=0, counters=0.
- Load throughput: one byte per clk while ld_valid is held high.
- ld_start at edge n: busy=1 and ld_ready=1 from n+1.
- Last byte accepted at edge m: CHECK during m+1; done high during cycle m+1..m+2; busy=0 from m+2.
- ld_len=0: ld_start at n, done pulse in cycle n+1, busy=0 from n+2.
- Fetch latency: addr sampled at negedge; dout is valid half a cycle before the next posedge. A byte written at posedge p is fetchable from the negedge after p, provided busy=0 at that negedge.
- Simultaneous events:
  - ld_valid while in IDLE is ignored.
  - A fetch at the same negedge busy falls returns NOP_WORD if busy is still 1 at that edge.

## Configuration
- PROG_MEM_CHECKSUM_EN defined: sum register, ld_chk latch and compare are built; chk_err behaves as specified above.
- PROG_MEM_CHECKSUM_EN undefined: no sum logic; chk_err is tied to 0 and ld_chk is ignored. CHECK remains one cycle, so timing is identical in both builds.

## Structure
- The shared package `mcu51_pkg` holds the state encoding (IDLE=2'd0, LOAD=2'd1, CHECK=2'd2) and the NOP opcode constant 8'h00.
- One sub-module, `prog_mem_ram`: a DEPTH×DATAWIDTH array with a posedge write port and a negedge registered read port. The loader FSM, counters and checksum stay in the top module.

## Test plan
- Reset, then CS=0, addr=0 -> dout=8'h00; with CS=1 -> dout=high-Z; busy=0, ld_ready=0.
- Load base=0, len=3, chk=8'h83 with bytes 74,07,08 streamed back-to-back -> done exactly 3 cycles after the first transfer, then fetches at addr 0,1,2 return 74,07,08, and chk_err=0.
- Same load with chk=8'h84 -> chk_err=1 after done, and it stays 1 until the next ld_start; without PROG_MEM_CHECKSUM_EN -> chk_err stays 0.
- base=8'hFE, len=4, bytes A1..A4 with ld_valid toggling every other cycle -> bytes land at FE,FF,00,01; busy lasts 8+1 cycles; no bytes are lost.
- Fetch addr=0 during the load -> 8'h00 every cycle; a second ld_start mid-load -> ignored, and len is not re-latched.
- rst asserted after 2 of 4 bytes -> all outputs return to reset values at once; mem[base], mem[base+1] hold the new bytes and mem[base+2] keeps its old value.

Source files
------------

// File: rtl/mcu51_pkg.sv
// Shared MCU51 definitions: loader state encoding and the NOP opcode.
package mcu51_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } ld_state_t;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

endpackage

// File: rtl/prog_mem_ram.sv
// Program store: posedge write port, negedge registered read port that
// returns NOP_WORD instead of the array contents while blanked.
module prog_mem_ram #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 8,
  parameter logic [DATAWIDTH-1:0] NOP_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic                 blank,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  // The array is deliberately not reset so a reset keeps loaded code.
  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (blank) q <= NOP_WORD;
    else            q <= mem[raddr];
  end

endmodule

// File: rtl/prog_byte_mem.sv
// Loadable MCU51 program memory: byte-stream loader FSM plus CPU fetch port.
// Optional checksum compare is built when PROG_MEM_CHECKSUM_EN is defined.
module prog_byte_mem
  import mcu51_pkg::*;
#(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 8,
  parameter logic [DATAWIDTH-1:0] NOP_WORD = DATAWIDTH'(NOP_OPCODE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CS,
  input  logic [ADDRWIDTH-1:0] addr,
  output logic [DATAWIDTH-1:0] dout,
  input  logic                 ld_start,
  input  logic [ADDRWIDTH-1:0] ld_base,
  input  logic [ADDRWIDTH:0]   ld_len,
  input  logic [DATAWIDTH-1:0] ld_chk,
  input  logic                 ld_valid,
  input  logic [DATAWIDTH-1:0] ld_data,
  output logic                 ld_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 chk_err
);

  localparam logic [ADDRWIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDRWIDTH:0]   CNT_ONE = 1;

  ld_state_t state, state_nxt;

  logic [ADDRWIDTH-1:0] ptr;
  logic [ADDRWIDTH:0]   len;
  logic [ADDRWIDTH:0]   cnt;
  logic [ADDRWIDTH:0]   cnt_inc;
  logic [DATAWIDTH-1:0] data;
  logic                 xfer;
  logic                 start_ok;

  assign cnt_inc  = cnt + CNT_ONE;
  assign busy     = (state != IDLE);
  assign start_ok = (state == IDLE) && ld_start;
  assign xfer     = (state == LOAD) && ld_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) state_nxt = (ld_len == '0) ? CHECK : LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && (cnt_inc == len)) state_nxt = CHECK;
      end
      CHECK: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      len <= '0;
      cnt <= '0;
    end else if (start_ok) begin
      ptr <= ld_base;
      len <= ld_len;
      cnt <= '0;
    end else if (xfer) begin
      ptr <= ptr + PTR_ONE;
      cnt <= cnt_inc;
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATAWIDTH-1:0] sum;
  logic [DATAWIDTH-1:0] chk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      chk     <= '0;
      chk_err <= 1'b0;
    end else if (start_ok) begin
      sum     <= '0;
      chk     <= ld_chk;
      chk_err <= 1'b0;
    end else if (xfer) begin
      sum <= sum + ld_data;
    end else if (state == CHECK) begin
      chk_err <= (sum != chk);
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^ld_chk;
  assign chk_err    = 1'b0;
`endif

  // Fetch path is blanked for the whole load so the CPU executes NOPs.
  prog_mem_ram #(
    .ADDRWIDTH(ADDRWIDTH),
    .DATAWIDTH(DATAWIDTH),
    .NOP_WORD (NOP_WORD)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (xfer),
    .waddr(ptr),
    .wdata(ld_data),
    .blank(busy),
    .raddr(addr),
    .q    (data)
  );

  assign dout = CS ? 'z : data;

endmodule

// File: tb/tb_prog_byte_mem.sv
// Directed self-checking bench for prog_byte_mem (load, fetch, checksum, reset).
module tb_prog_byte_mem;

`ifdef PROG_MEM_CHECKSUM_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic [7:0] addr;
  tri0  [7:0] dout;
  logic       ld_start;
  logic [7:0] ld_base;
  logic [8:0] ld_len;
  logic [7:0] ld_chk;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       busy;
  logic       done;
  logic       chk_err;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cyc, done_pos, done_cnt;

  prog_byte_mem dut (
    .clk     (clk),
    .rst     (rst),
    .CS      (cs),
    .addr    (addr),
    .dout    (dout),
    .ld_start(ld_start),
    .ld_base (ld_base),
    .ld_len  (ld_len),
    .ld_chk  (ld_chk),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_ready(ld_ready),
    .busy    (busy),
    .done    (done),
    .chk_err (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input bit nop_chk);
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      done_pos = busy_cyc;
    end
    if (nop_chk) check("nop_during_load", dout, 8'h00);
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    tick;
    check(tag, dout, exp);
  endtask

  // bytes are packed MSB-first; gap = idle cycles before each byte
  task automatic run_load(input logic [7:0] base, input logic [8:0] len, input logic [7:0] chk,
                          input logic [31:0] bytes, input int nbytes, input int gap,
                          input bit mid_start, input bit nop_chk);
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    ld_chk   = chk;
    tick;
    ld_start = 1'b0;
    busy_cyc = 0;
    done_pos = 0;
    done_cnt = 0;
    observe(1'b0);
    for (int i = 0; i < nbytes; i++) begin
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0;
        if (mid_start && i == 0 && g == 0) begin
          ld_start = 1'b1;
          ld_base  = 8'h10;
          ld_len   = 9'd1;
          ld_chk   = 8'h55;
        end
        tick;
        ld_start = 1'b0;
        observe(nop_chk);
      end
      ld_valid = 1'b1;
      ld_data  = bytes[31-8*i -: 8];
      tick;
      observe(nop_chk);
    end
    ld_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!busy) break;
      tick;
      observe(nop_chk);
    end
    check("load_terminates", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs = 1'b0; addr = 8'h00;
    ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_chk = '0;
    ld_valid = 1'b0; ld_data = '0;
    #12;
    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ld_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_chk_err", chk_err, 1'b0);
    rst = 1'b0;
    tick;
    ld_valid = 1'b1; ld_data = 8'hEE;
    tick;
    check("idle_valid_ignored", ld_ready, 1'b0);
    ld_valid = 1'b0;

    // back-to-back load, good checksum 74+07+08 = 83
    run_load(8'h00, 9'd3, 8'h83, 32'h74070800, 3, 0, 1'b0, 1'b0);
    check("l1_busy_cycles", busy_cyc, 4);
    check("l1_done_pos", done_pos, 4);
    check("l1_done_cnt", done_cnt, 1);
    check("l1_chk_err", chk_err, 1'b0);
    fetch(8'h00, 8'h74, "l1_mem0");
    fetch(8'h01, 8'h07, "l1_mem1");
    fetch(8'h02, 8'h08, "l1_mem2");
    addr = 8'h00;
    tick;
    cs = 1'b1;
    #1;
    check("cs_high_z", dout, 8'h00);
    cs = 1'b0;
    #1;
    check("cs_low_data", dout, 8'h74);

    // bad checksum, sticky error
    run_load(8'h00, 9'd3, 8'h84, 32'h74070800, 3, 0, 1'b0, 1'b0);
    check("l2_chk_err", chk_err, CE);
    tick; tick; tick;
    check("l2_chk_err_sticky", chk_err, CE);

    // zero-length load clears the error
    run_load(8'h40, 9'd0, 8'h00, 32'h0, 0, 0, 1'b0, 1'b0);
    check("l0_busy_cycles", busy_cyc, 1);
    check("l0_done_pos", done_pos, 1);
    check("l0_done_cnt", done_cnt, 1);
    check("l0_chk_err_clear", chk_err, 1'b0);

    // wrapping load with toggling valid, fetch blanked, ignored restart
    addr = 8'h00;
    run_load(8'hFE, 9'd4, 8'h8A, 32'hA1A2A3A4, 4, 1, 1'b1, 1'b1);
    check("l4_busy_cycles", busy_cyc, 9);
    check("l4_done_pos", done_pos, 9);
    check("l4_done_cnt", done_cnt, 1);
    check("l4_chk_err", chk_err, 1'b0);
    fetch(8'hFE, 8'hA1, "l4_memFE");
    fetch(8'hFF, 8'hA2, "l4_memFF");
    fetch(8'h00, 8'hA3, "l4_mem00");
    fetch(8'h01, 8'hA4, "l4_mem01");

    // reset in mid-load
    run_load(8'h20, 9'd4, 8'h00, 32'h11223344, 4, 0, 1'b0, 1'b0);
    check("l5a_done_cnt", done_cnt, 1);
    addr = 8'h20;
    ld_start = 1'b1; ld_base = 8'h20; ld_len = 9'd4; ld_chk = 8'h00;
    tick;
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h55;
    tick;
    ld_data = 8'h66;
    tick;
    ld_data = 8'h77;
    check("l5_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("l5_rst_busy", busy, 1'b0);
    check("l5_rst_ready", ld_ready, 1'b0);
    check("l5_rst_done", done, 1'b0);
    check("l5_rst_chk_err", chk_err, 1'b0);
    check("l5_rst_dout", dout, 8'h00);
    tick;
    rst = 1'b0;
    ld_valid = 1'b0;
    fetch(8'h20, 8'h55, "l5_mem20");
    fetch(8'h21, 8'h66, "l5_mem21");
    fetch(8'h22, 8'h33, "l5_mem22_old");
    fetch(8'h23, 8'h44, "l5_mem23_old");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
